// File: rtl/pcie_lane_lock_ctrl.sv
// pcie_lane_lock_ctrl: per-lane COM symbol lock counting and link bring-up FSM
// (IDLE -> DETECT -> LOCK -> UP) with a LOCK-phase timeout.
module pcie_lane_lock_ctrl #(
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic         Clk,
    input  logic         notReset,
    input  logic [159:0] LinkIn,
    input  logic [15:0]  ElecIdleIn,
    input  logic [4:0]   LinkWidth,
    input  logic         Disable8b10b,
    output logic [15:0]  LaneLock,
    output logic         LinkUp,
    output logic [1:0]   State,
    output logic         TimeoutErr
);
    typedef enum logic [1:0] {IDLE, DETECT, LOCK, UP} state_t;
    state_t      state, nxt;
    logic [4:0]  width;
    logic [15:0] active, com, clr, idle_act;
    logic [3:0]  cnt [16];
    logic [15:0] timer;
    logic        all_lock, any_idle, timeout, counting;
    always_comb begin
        width    = LinkWidth == 5'd0 ? 5'd1 : LinkWidth > 5'd16 ? 5'd16 : LinkWidth;
        idle_act = ElecIdleIn & active;
        any_idle = |idle_act;
        all_lock = (LaneLock & active) == active;
        counting = state == LOCK || state == UP;
        timeout  = state == LOCK && !any_idle && !all_lock && timer == 16'(TIMEOUT - 1);
        nxt      = state == IDLE   ? DETECT :
                   state == DETECT ? (any_idle ? DETECT : LOCK) :
                   state == LOCK   ? (any_idle ? DETECT : all_lock ? UP : timeout ? IDLE : LOCK) :
                                     (any_idle || !all_lock ? DETECT : UP);
    end
    for (genvar g = 0; g < 16; g++) begin : g_lane
        assign active[g] = 5'(g) < width;
        assign com[g]    = Disable8b10b ? LinkIn[10*g +: 9] == 9'h1BC
                                        : LinkIn[10*g +: 10] == 10'h0FA || LinkIn[10*g +: 10] == 10'h305;
        // Idle/inactive lanes and any non-counting next state wipe the lane.
        assign clr[g]    = !active[g] || ElecIdleIn[g] || nxt == IDLE || nxt == DETECT;
    end
    assign State = state;
    always_ff @(posedge Clk) begin
        if (!notReset) begin
            state      <= IDLE;
            LinkUp     <= 1'b0;
            TimeoutErr <= 1'b0;
            timer      <= 16'd0;
            LaneLock   <= 16'd0;
            for (int i = 0; i < 16; i++) cnt[i] <= 4'd0;
        end else begin
            state      <= nxt;
            LinkUp     <= nxt == UP;
            TimeoutErr <= timeout;
            timer      <= state == LOCK && nxt == LOCK ? timer + 16'd1 : 16'd0;
            for (int i = 0; i < 16; i++) begin
                cnt[i]      <= clr[i] ? 4'd0 :
                               com[i] && counting && cnt[i] != 4'hF ? cnt[i] + 4'd1 : cnt[i];
                LaneLock[i] <= !clr[i] && cnt[i] >= 4'(LOCK_COUNT);
            end
        end
    end
endmodule

// File: tb/tb_pcie_lane_lock_ctrl.sv
// tb_pcie_lane_lock_ctrl: directed bring-up, drop, timeout, width and raw-symbol
// scenarios with hand-computed expectations.
module tb_pcie_lane_lock_ctrl;
    logic         Clk = 1'b0;
    logic         notReset = 1'b0;
    logic [159:0] LinkIn = '0;
    logic [15:0]  ElecIdleIn = '0;
    logic [4:0]   LinkWidth = 5'd4;
    logic         Disable8b10b = 1'b0;
    logic [15:0]  LaneLock;
    logic         LinkUp;
    logic [1:0]   State;
    logic         TimeoutErr;
    int checks = 0;
    int failures = 0;

    pcie_lane_lock_ctrl #(.LOCK_COUNT(4), .TIMEOUT(64)) dut (
        .Clk(Clk), .notReset(notReset), .LinkIn(LinkIn), .ElecIdleIn(ElecIdleIn),
        .LinkWidth(LinkWidth), .Disable8b10b(Disable8b10b), .LaneLock(LaneLock),
        .LinkUp(LinkUp), .State(State), .TimeoutErr(TimeoutErr)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] mask, input logic [9:0] sym);
        for (int i = 0; i < 16; i++) LinkIn[10*i +: 10] = mask[i] ? sym : 10'h000;
    endtask

    task automatic com_pulse(input logic [15:0] mask, input int gap);
        drive(mask, 10'h0FA);
        tick();
        LinkIn = '0;
        repeat (gap) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        tick();
        check("rst_state", State, 0);
        check("rst_lock", LaneLock, 0);
        check("rst_up", LinkUp, 0);
        check("rst_terr", TimeoutErr, 0);
        // width 4 bring-up, COM every 16 cycles
        notReset = 1'b1;
        tick();
        check("detect", State, 1);
        tick();
        check("lock_entry", State, 2);
        for (int k = 0; k < 3; k++) com_pulse(16'h000F, 15);
        drive(16'h000F, 10'h0FB);
        tick();
        check("noncom_ignored", LaneLock, 0);
        com_pulse(16'h000F, 0);
        check("before_lock", LaneLock, 0);
        tick();
        check("lanelock_f", LaneLock, 16'h000F);
        check("still_lock", State, 2);
        check("up_not_yet", LinkUp, 0);
        tick();
        check("up_state", State, 3);
        check("linkup", LinkUp, 1);
        // lane 2 idle for one cycle while UP
        ElecIdleIn = 16'h0004;
        tick();
        ElecIdleIn = '0;
        check("drop_lane2", LaneLock[2], 0);
        check("drop_linkup", LinkUp, 0);
        check("drop_state", State, 1);
        tick();
        check("relock_entry", State, 2);
        for (int k = 0; k < 3; k++) com_pulse(16'h000F, 1);
        com_pulse(16'h000F, 0);
        tick();
        check("relock_lanes", LaneLock, 16'h000F);
        tick();
        check("relock_up", State, 3);
        // one-cycle reset while UP
        notReset = 1'b0;
        tick();
        notReset = 1'b1;
        check("mid_rst_state", State, 0);
        check("mid_rst_lock", LaneLock, 0);
        check("mid_rst_up", LinkUp, 0);
        check("mid_rst_terr", TimeoutErr, 0);
        tick();
        check("post_rst_detect", State, 1);
        // width 2, lane 1 silent -> timeout
        LinkWidth = 5'd2;
        tick();
        check("to_entry", State, 2);
        for (int k = 0; k < 4; k++) com_pulse(16'h0003 & 16'h0001, 0);
        repeat (59) tick();
        check("to_pre_terr", TimeoutErr, 0);
        check("to_pre_state", State, 2);
        check("to_partial_lock", LaneLock, 16'h0001);
        tick();
        check("to_pulse", TimeoutErr, 1);
        check("to_idle", State, 0);
        check("to_lock_clr", LaneLock, 0);
        tick();
        check("to_pulse_end", TimeoutErr, 0);
        check("to_detect", State, 1);
        // width 0 -> one lane, then 20 -> sixteen lanes
        LinkWidth = 5'd0;
        tick();
        check("w1_lock", State, 2);
        for (int k = 0; k < 4; k++) com_pulse(16'hFFFF, 0);
        tick();
        check("w1_lanes", LaneLock, 16'h0001);
        tick();
        check("w1_up", State, 3);
        LinkWidth = 5'd20;
        tick();
        check("w16_exit", State, 1);
        check("w16_linkup", LinkUp, 0);
        tick();
        check("w16_lock", State, 2);
        for (int k = 0; k < 4; k++) com_pulse(16'hFFFF, 0);
        tick();
        check("w16_lanes", LaneLock, 16'hFFFF);
        tick();
        check("w16_up", State, 3);
        // raw symbols: 1BC and 3BC are COM, 0BC is not
        LinkWidth = 5'd1;
        Disable8b10b = 1'b1;
        notReset = 1'b0;
        tick();
        notReset = 1'b1;
        tick();
        tick();
        check("raw_lock_state", State, 2);
        drive(16'h0001, 10'h1BC); tick();
        drive(16'h0001, 10'h3BC); tick();
        drive(16'h0001, 10'h0BC); tick();
        drive(16'h0001, 10'h1BC); tick();
        LinkIn = '0;
        tick();
        check("raw_three", LaneLock, 0);
        drive(16'h0001, 10'h3BC); tick();
        LinkIn = '0;
        tick();
        check("raw_locked", LaneLock, 16'h0001);
        tick();
        check("raw_up", State, 3);
        // idle beats a simultaneous COM
        drive(16'h0001, 10'h1BC);
        ElecIdleIn = 16'h0001;
        tick();
        LinkIn = '0;
        ElecIdleIn = '0;
        check("idle_prio_state", State, 1);
        check("idle_prio_lock", LaneLock, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
